// File: rtl/seven_segment_capture.sv
// -----------------------------------------------------------------------------
// seven_segment_capture
//
// Receive side of a multiplexed 4-digit seven-segment display (the stopwatch
// display bus). It watches the active-low anode and cathode buses. Each digit
// slot must be held stable before it is accepted. Accepted cathode patterns are
// decoded back to BCD, and a complete set of four slots is reassembled into
// binary minutes and seconds.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   anode_in[3:0]  active-low digit enables (0111 min tens, 1011 min ones,
//                  1101 sec tens, 1110 sec ones, 1111 blanking)
//   segment_in[6:0] active-low cathodes, bit6 = a ... bit0 = g
//   minutes[6:0]   binary minutes of the last complete frame
//   seconds[6:0]   binary seconds of the last complete frame
//   digits_bcd[15:0] {min_tens, min_ones, sec_tens, sec_ones} of last frame
//   frame_valid    one-cycle pulse when the frame outputs update
//   segment_error  one-cycle pulse: accepted slot had an undecodable pattern
//   anode_error    one-cycle pulse: accepted sample had several anodes low
// -----------------------------------------------------------------------------
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  segment_in,
  output logic [6:0]  minutes,
  output logic [6:0]  seconds,
  output logic [15:0] digits_bcd,
  output logic        frame_valid,
  output logic        segment_error,
  output logic        anode_error
);

  localparam logic [CNT_W-1:0] AcceptCount = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SatCount    = CNT_W'(STABLE_CYCLES);
  localparam logic [10:0]      IdleSample  = 11'h7FF;

  // Synchronizer and stability tracking
  logic [10:0]      sync1_q;
  logic [10:0]      sample_q;
  logic [10:0]      prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Capture state
  logic [15:0] work_q;
  logic [15:0] work_d;
  logic [3:0]  seen_q;
  logic [3:0]  seen_d;
  logic        complete_q;
  logic        complete_d;

  // Registered outputs
  logic [6:0]  minutes_q;
  logic [6:0]  seconds_q;
  logic [15:0] digits_q;
  logic        frameValid_q;
  logic        segErr_q;
  logic        segErr_d;
  logic        anErr_q;
  logic        anErr_d;

  // Decoded view of the current synchronized sample
  logic       accept;
  logic [3:0] anode;
  logic [6:0] segment;
  logic       slotValid;
  logic [1:0] slotIdx;
  logic       blank;
  logic       decOk;
  logic [3:0] decVal;

  function automatic logic [6:0] times10(input logic [3:0] t);
    logic [6:0] w;
    w = {3'b000, t};
    return (w << 3) + (w << 1);
  endfunction

  assign anode   = sample_q[10:7];
  assign segment = sample_q[6:0];
  assign blank   = (anode == 4'b1111);

  // The accept strobe fires once, on the cycle the counter passes
  // STABLE_CYCLES-1; saturation keeps a long hold from firing again.
  assign accept = (sample_q == prev_q) && (cnt_q == AcceptCount);

  // Two-flop synchronizer plus one extra stage for the change detector.
  // Reset values look like a blanked display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= IdleSample;
      sample_q <= IdleSample;
      prev_q   <= IdleSample;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= {anode_in, segment_in};
      sample_q <= sync1_q;
      prev_q   <= sample_q;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sample_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q < SatCount) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Slot index matches the nibble position in digits_bcd (3 = minutes tens).
  always_comb begin
    slotValid = 1'b1;
    slotIdx   = 2'd0;
    case (anode)
      4'b0111: slotIdx = 2'd3;
      4'b1011: slotIdx = 2'd2;
      4'b1101: slotIdx = 2'd1;
      4'b1110: slotIdx = 2'd0;
      default: slotValid = 1'b0;
    endcase
  end

  always_comb begin
    decOk  = 1'b1;
    decVal = 4'd0;
    case (segment)
      7'b0000001: decVal = 4'd0;
      7'b1001111: decVal = 4'd1;
      7'b0010010: decVal = 4'd2;
      7'b0000110: decVal = 4'd3;
      7'b1001100: decVal = 4'd4;
      7'b0100100: decVal = 4'd5;
      7'b0100000: decVal = 4'd6;
      7'b0001111: decVal = 4'd7;
      7'b0000000: decVal = 4'd8;
      7'b0000100: decVal = 4'd9;
      default:    decOk  = 1'b0;
    endcase
  end

  // Capture next-state. The seen mask is cleared first when a frame is
  // being published, so an accept landing on that same cycle survives.
  always_comb begin
    work_d     = work_q;
    seen_d     = complete_q ? 4'b0000 : seen_q;
    complete_d = 1'b0;
    segErr_d   = 1'b0;
    anErr_d    = 1'b0;
    if (accept) begin
      if (slotValid) begin
        if (decOk) begin
          work_d[{slotIdx, 2'b00} +: 4] = decVal;
          seen_d[slotIdx]               = 1'b1;
          complete_d                    = (seen_d == 4'b1111);
        end else begin
          segErr_d = 1'b1;
        end
      end else if (!blank) begin
        anErr_d = 1'b1;
      end
    end
  end

  // Capture registers and frame publication; the frame outputs are taken
  // from the working registers one cycle after the set became complete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_q       <= '0;
      seen_q       <= '0;
      complete_q   <= 1'b0;
      minutes_q    <= '0;
      seconds_q    <= '0;
      digits_q     <= '0;
      frameValid_q <= 1'b0;
      segErr_q     <= 1'b0;
      anErr_q      <= 1'b0;
    end else begin
      work_q       <= work_d;
      seen_q       <= seen_d;
      complete_q   <= complete_d;
      segErr_q     <= segErr_d;
      anErr_q      <= anErr_d;
      frameValid_q <= complete_q;
      if (complete_q) begin
        minutes_q <= times10(work_q[15:12]) + {3'b000, work_q[11:8]};
        seconds_q <= times10(work_q[7:4]) + {3'b000, work_q[3:0]};
        digits_q  <= work_q;
      end
    end
  end

  assign minutes       = minutes_q;
  assign seconds       = seconds_q;
  assign digits_bcd    = digits_q;
  assign frame_valid   = frameValid_q;
  assign segment_error = segErr_q;
  assign anode_error   = anErr_q;

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the stopwatch multiplexed display interface.
- Samples the 4-bit active-low anode bus and the 7-bit active-low cathode bus, qualifies each stable digit slot, and decodes the cathode pattern back to BCD.
- Reassembles complete frames into binary minutes/seconds.
- Used as a board-to-board display reader and as the self-check monitor in stopwatch benches.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a digit slot is accepted. Legal range 2..255.
- CNT_W, 8: stability counter width; must hold STABLE_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- anode_in  in  4  active-low digit enables. 0111 = minutes tens, 1011 = minutes ones, 1101 = seconds tens, 1110 = seconds ones.
- segment_in  in  7  active-low cathodes, bit6 = a … bit0 = g
- minutes  out  7  binary minutes from the last complete frame, 0..99
- seconds  out  7  binary seconds from the last complete frame, 0..99
- digits_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones} from the last complete frame
- frame_valid  out  1  one-cycle pulse when minutes/seconds/digits_bcd update
- segment_error  out  1  one-cycle pulse when an accepted slot carries an undecodable pattern
- anode_error  out  1  one-cycle pulse when an accepted sample has more than one anode low

Behaviour:
- Reset values:
  - Sync flops: anode = 4'b1111, segment = 7'b1111111.
  - Counter = 0; seen mask = 0; working digit regs = 0.
  - All outputs 0.
  - Reset asserted mid-frame discards partial captures; the next frame starts from an empty seen mask.
- Synchronizer: two-flop synchronizer on all 11 input bits. Synced sample s = {anode, segment}. s_prev holds s delayed one cycle.
- Stability counter:
  - If s != s_prev: cnt <= 0.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt + 1.
  - Saturates at STABLE_CYCLES.
- accept = (s == s_prev) && (cnt == STABLE_CYCLES-1). It fires exactly once per stable period; a period held indefinitely produces no second accept.
- On accept, by anode value:
  - Exactly one anode bit low, segment decodable: write the 4-bit value into that slot's working register and set its seen bit. Re-accepting an already-seen slot overwrites it.
  - Exactly one anode bit low, segment not decodable: segment_error pulse; working register and seen bit unchanged.
  - Anode = 1111 (blanking): ignored, no error.
  - Two or more anode bits low: anode_error pulse; nothing written.
- Decode table (segment_in → value); anything else is an error:
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3, 1001100 → 4
  - 0100100 → 5, 0100000 → 6, 0001111 → 7, 0000000 → 8, 0000100 → 9
- Frame completion:
  - When the seen mask becomes 4'b1111 on an accept edge, on the following edge:
    - minutes <= min_tens*10 + min_ones;
    - seconds <= sec_tens*10 + sec_ones;
    - digits_bcd <= working regs;
    - frame_valid = 1 for that cycle;
    - seen mask cleared.
  - An accept arriving in the same cycle as the clear is written and its seen bit is set after the clear, so no capture is lost.
- Arithmetic: tens*10 done as (t<<3)+(t<<1) in 7 bits; max 99, no overflow.
- Latency: a digit pattern held steady from edge 0 is accepted at edge STABLE_CYCLES+3. If that accept completes the frame, frame_valid is high after edge STABLE_CYCLES+4.
- Glitches: input changes shorter than STABLE_CYCLES synced cycles are never accepted.
- Slot order: no ordering is enforced. Any order of the four slots completes a frame.
- Error pulses do not block frame completion once all four slots have been captured legally.
- Outputs are registered; minutes/seconds/digits_bcd hold their value between frames.

Test Plan:
- Reset, then drive anode=1111, segment=1111111 for 100 cycles → all outputs 0, no pulses.
- STABLE_CYCLES=4. Present slots 0111/0010010, 1011/0100100, 1101/0000110, 1110/0000000, each held 20 cycles → one frame_valid, minutes=25, seconds=38, digits_bcd=16'h2538. Pulse occurs 8 edges after the fourth slot is applied.
- Present the same slots, but insert a 2-cycle glitch of 1011/0000000 inside the minutes-tens hold → result unchanged (minutes=25); no extra accept.
- Present seconds-ones slot with segment=1111110 → segment_error pulses once, no frame_valid. Then present a legal 1110/1001111 → frame_valid, seconds=31.
- Drive anode=0011 stable → anode_error pulses exactly once; seen mask unchanged.
- Assert reset after two slots are captured, release, then present the last two slots only → no frame_valid until all four slots are re-captured.
